// File: rtl/fx_pkg.sv
// fx_pkg: shared FX bus widths, register offsets and register bit positions
package fx_pkg;
    localparam int FX_AW = 16;
    localparam int FX_DW = 8;
    localparam logic [7:0] REG_ID     = 8'h00;
    localparam logic [7:0] REG_CTRL   = 8'h01;
    localparam logic [7:0] REG_STATUS = 8'h02;
    localparam logic [7:0] REG_COUNT  = 8'h03;
    localparam logic [7:0] REG_DATA_L = 8'h04;
    localparam logic [7:0] REG_DATA_H = 8'h05;
    localparam int CTRL_CAP_EN   = 0;
    localparam int CTRL_FIFO_CLR = 1;
    localparam int CTRL_OVF_CLR  = 2;
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
endpackage

// File: rtl/fx_fifo_sync.sv
// fx_fifo_sync: synchronous first-word-fall-through FIFO with wrapping pointers and occupancy count
module fx_fifo_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clr,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];
    // pointers and count; a full FIFO still accepts a push when it is popped the same cycle
    always_ff @(posedge clk_sys) begin
        if (rst || clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage array, no reset needed since the count gates visibility
    always_ff @(posedge clk_sys) begin
        if (do_push && !clr) mem[wp] <= wdata;
    end
endmodule

// File: rtl/fx_ad_cap.sv
// fx_ad_cap: ADC sample capture FIFO exposed as an FX bus register slave
module fx_ad_cap
    import fx_pkg::*;
#(
    parameter logic [7:0] DEV_ID = 8'h02,
    parameter logic [7:0] ID_VAL = 8'hA1,
    parameter int         DEPTH  = 16
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [15:0]      ad_data,
    input  logic             ad_vld,
    input  logic             fx_wr,
    input  logic [FX_AW-1:0] fx_waddr,
    input  logic [FX_DW-1:0] fx_data,
    input  logic             fx_rd,
    input  logic [FX_AW-1:0] fx_raddr,
    output logic [FX_DW-1:0] fx_q
);
    logic [15:0] head;
    logic [$clog2(DEPTH):0] count;
    logic [8:0] count9;
    logic [7:0] count_b, status, rdata, hold;
    logic empty, full, cap_en, ovf;
    logic rd_sel, wr_ctrl, fifo_clr, ovf_clr, rd_data_l, push, pop, ovf_set;
    logic unused_ok;
    assign rd_sel    = fx_rd && fx_raddr[15:8] == DEV_ID;
    assign wr_ctrl   = fx_wr && fx_waddr[15:8] == DEV_ID && fx_waddr[7:0] == REG_CTRL;
    assign fifo_clr  = wr_ctrl && fx_data[CTRL_FIFO_CLR];
    assign ovf_clr   = wr_ctrl && fx_data[CTRL_OVF_CLR];
    assign rd_data_l = rd_sel && fx_raddr[7:0] == REG_DATA_L;
    assign push      = ad_vld && cap_en;
    assign pop       = rd_data_l;
    assign ovf_set   = push && full && !(pop && !empty) && !fifo_clr;
    assign count9    = 9'(count);
    assign count_b   = count9[8] ? 8'hFF : count9[7:0];
    assign unused_ok = ^fx_data[7:3];

    fx_fifo_sync #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .rst     (rst),
        .push    (push),
        .wdata   (ad_data),
        .pop     (pop),
        .clr     (fifo_clr),
        .head    (head),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    // read mux from current state, before this cycle's push/pop or CTRL write
    always_comb begin
        status = '0;
        status[STAT_EMPTY] = empty;
        status[STAT_FULL]  = full;
        status[STAT_OVF]   = ovf;
        rdata = fx_raddr[7:0] == REG_ID     ? ID_VAL :
                fx_raddr[7:0] == REG_CTRL   ? {7'b0, cap_en} :
                fx_raddr[7:0] == REG_STATUS ? status :
                fx_raddr[7:0] == REG_COUNT  ? count_b :
                fx_raddr[7:0] == REG_DATA_L ? (empty ? 8'h00 : head[7:0]) :
                fx_raddr[7:0] == REG_DATA_H ? hold : 8'h00;
    end

    // registered read response (zero when idle for OR-aggregation), control and sticky state
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fx_q   <= '0;
            cap_en <= 1'b0;
            ovf    <= 1'b0;
            hold   <= '0;
        end else begin
            fx_q <= rd_sel ? rdata : 8'h00;
            if (wr_ctrl) cap_en <= fx_data[CTRL_CAP_EN];
            ovf  <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;
            hold <= fifo_clr ? 8'h00 : rd_data_l ? (empty ? 8'h00 : head[15:8]) : hold;
        end
    end
endmodule

// File: doc/fx_ad_cap.md
# fx_ad_cap

ADC sample capture slave on the FX register bus. It buffers 16-bit ADC samples in a small synchronous FIFO and exposes them, with control and status registers, as an FX bus read/write slave. Its `fx_q` output is one of the per-slave inputs that the FX bus aggregator ORs together. It therefore drives all-zero whenever it is not answering a read addressed to it.

## Interface
Parameters:
- `DEV_ID`, 8'h02, device select matched against address bits [15:8]
- `ID_VAL`, 8'hA1, constant returned by the ID register
- `DEPTH`, 16, FIFO entries; must be a power of 2, range 4..256

Ports:
- `clk_sys`  in  1  system clock; all logic is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `ad_data`  in  16  ADC sample
- `ad_vld`  in  1  `ad_data` valid this cycle
- `fx_wr`  in  1  one-cycle write strobe
- `fx_waddr`  in  16  write address; [15:8] device, [7:0] register
- `fx_data`  in  8  write data
- `fx_rd`  in  1  one-cycle read strobe
- `fx_raddr`  in  16  read address
- `fx_q`  out  8  read data to the bus aggregator; 0 when idle

## Operation
Register map (offset = address [7:0]). An access is selected only when address [15:8] == `DEV_ID`. Writes to other offsets are ignored. Reads of other offsets return 0x00.
- 0x00 ID (RO): returns `ID_VAL`.
- 0x01 CTRL (RW):
  - bit0 `cap_en`, reads back.
  - bit1 `fifo_clr`: write-1 pulse, reads 0.
  - bit2 `ovf_clr`: write-1 pulse, reads 0.
  - bits 7:3 read 0.
- 0x02 STATUS (RO): bit0 empty, bit1 full, bit2 `ovf` (sticky), others 0.
- 0x03 COUNT (RO): current occupancy, 0..`DEPTH`, saturates the byte field.
- 0x04 DATA_L (RO): returns `head[7:0]`, pops the FIFO and loads `hold <= head[15:8]`. If the FIFO is empty it returns 0x00, does not pop and loads `hold <= 0`.
- 0x05 DATA_H (RO): returns `hold`. No side effects.

Capture and FIFO behaviour:
- Capture: when `ad_vld` && `cap_en`, `ad_data` is pushed. When `cap_en` = 0, `ad_vld` is ignored.
- Push when full: the sample is dropped and `ovf` is set. FIFO contents are unchanged.
- Push and pop in the same cycle (also when full): both occur and count is unchanged. Full-with-pop does not set `ovf`.
- `fifo_clr`: empties the FIFO (pointers and count to 0) and clears `hold`. It overrides a same-cycle push or pop.
- `ovf` set and `ovf_clr` in the same cycle: set wins.
- Simultaneous `fx_wr` and `fx_rd` are legal and independent. A same-cycle CTRL write does not affect the read data returned that cycle.

## Timing
- Read latency is 1. When `fx_rd` is high in cycle N to a selected address, `fx_q` carries the data in cycle N+1 only. In every other cycle `fx_q` = 8'h00.
- Read data are registered from the state at cycle N, before that cycle's push or pop.
- A pop caused by a DATA_L read takes effect at the cycle N edge. A DATA_L read in N+1 returns the next entry.
- A write takes effect at the edge ending its strobe cycle. `cap_en` gates `ad_vld` from cycle N+1.
- The push path has no bubble: a sample accepted at edge N is readable via DATA_L in cycle N+1.
- Reset values: `fx_q` = 0, `cap_en` = 0, `ovf` = 0, `hold` = 0, FIFO empty (count 0). Reset mid-operation discards all buffered data and any pending read response.

## Structure
- Shared package `fx_pkg`:
  - FX bus widths (address 16, data 8).
  - Register offset constants (ID, CTRL, STATUS, COUNT, DATA_L, DATA_H).
  - CTRL and STATUS bit positions.
- Sub-module `fx_fifo_sync`:
  - Parameters: width, depth.
  - Ports: push, pop, clr, head data, count, empty, full.
  - Implementation: `$clog2(DEPTH)`-bit wrapping pointers plus a count register one bit wider; first-word-fall-through head.
- The top level holds the address decode, CTRL/STATUS, `hold` and the registered `fx_q`.

## Test plan
- Reset, then read ID at 0x0200 → `fx_q` = 0xA1 for exactly one cycle. Read 0x0300 (other device) → `fx_q` stays 0x00 on all cycles.
- `cap_en` = 1, push 0x1234 then 0xABCD. Read DATA_L, DATA_H, DATA_L, DATA_H → 0x34, 0x12, 0xCD, 0xAB. COUNT 2 → 1 → 0 and STATUS.empty = 1.
- Push 17 samples 0x0000..0x0010 with no reads → COUNT = 16, STATUS = 0x06 (full and `ovf`). Drain returns 0x0000..0x000F. Write CTRL 0x05 → `ovf` = 0.
- With the FIFO full, assert `ad_vld` in the same cycle as a DATA_L read → one entry is popped and the new sample is appended, COUNT stays 16, `ovf` stays 0.
- With 5 entries, write CTRL 0x03 while `ad_vld` is high → COUNT = 0, the sample is dropped, `cap_en` stays 1. DATA_L on empty → 0x00 and DATA_H → 0x00.
- Assert `rst` for one cycle with 8 entries and a read in flight → next-cycle `fx_q` = 0x00, COUNT = 0, CTRL reads 0x00.
